// File: rtl/program_store_loader.sv
// Switch-keyed instruction store: debounced byte loader, registered fetch port and core reset control.
// Optional running checksum of loaded bytes is built only when PROGRAM_CHECKSUM_EN is defined.
module program_store_loader #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mode_load,
  input  logic                  load_strobe,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [ADDR_WIDTH-1:0] instruction_address,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH-1:0] load_address,
  output logic                  load_full,
  output logic [1:0]            state,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10
  } state_t;

  state_t state_q, next_state;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic          strobe_sync1, strobe_sync2;
  logic [CW-1:0] db_count;
  logic          db_level, db_level_d;
  logic          write_pulse, write_en, enter_load;

  assign state       = state_q;
  assign write_pulse = db_level & ~db_level_d;
  assign enter_load  = (state_q != LOAD) && (next_state == LOAD);
  // A pulse coinciding with the LOAD->RUN switch is dropped by requiring LOAD to persist.
  assign write_en    = (state_q == LOAD) && (next_state == LOAD) && write_pulse && !load_full;

  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE:    next_state = mode_load ? LOAD : RUN;
      LOAD:    if (!mode_load) next_state = RUN;
      RUN:     if (mode_load)  next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cpu_reset <= 1'b1;
    end else begin
      state_q   <= next_state;
      cpu_reset <= (state_q != RUN);
    end
  end

  // Level only flips after DEBOUNCE_CYCLES consecutive samples disagreeing with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      strobe_sync1 <= 1'b0;
      strobe_sync2 <= 1'b0;
      db_count     <= '0;
      db_level     <= 1'b0;
      db_level_d   <= 1'b0;
    end else begin
      strobe_sync1 <= load_strobe;
      strobe_sync2 <= strobe_sync1;
      db_level_d   <= db_level;
      if (strobe_sync2 != db_level) begin
        if (db_count == DB_LAST) begin
          db_level <= strobe_sync2;
          db_count <= '0;
        end else begin
          db_count <= db_count + 1'b1;
        end
      end else begin
        db_count <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      load_address <= '0;
      load_full    <= 1'b0;
    end else if (enter_load) begin
      load_address <= '0;
      load_full    <= 1'b0;
    end else if (write_en) begin
      load_address <= load_address + 1'b1;
      if (load_address == {ADDR_WIDTH{1'b1}}) load_full <= 1'b1;
    end
  end

  // RAM has no reset so a program survives a board reset.
  always_ff @(posedge clock) begin
    if (write_en && !reset) mem[load_address] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (reset)                instruction <= '0;
    else if (state_q == RUN)  instruction <= mem[instruction_address];
    else                      instruction <= '0;
  end

`ifdef PROGRAM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;

  always_ff @(posedge clock) begin
    if (reset)           checksum_q <= '0;
    else if (enter_load) checksum_q <= '0;
    else if (write_en)   checksum_q <= checksum_q + load_data;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_program_store_loader.sv
// Directed self-checking bench for program_store_loader; expected checksum follows PROGRAM_CHECKSUM_EN.
module tb_program_store_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode_load;
  logic       load_strobe;
  logic [7:0] load_data;
  logic [7:0] instruction_address;
  logic [7:0] instruction;
  logic       cpu_reset;
  logic [7:0] load_address;
  logic       load_full;
  logic [1:0] state;
  logic [7:0] checksum;

  int checks = 0;
  int errors = 0;
  logic [7:0] sum_model;
  logic [7:0] first_byte;

  program_store_loader #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset), .mode_load(mode_load), .load_strobe(load_strobe),
    .load_data(load_data), .instruction_address(instruction_address),
    .instruction(instruction), .cpu_reset(cpu_reset), .load_address(load_address),
    .load_full(load_full), .state(state), .checksum(checksum)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clean button press: held long enough to debounce, then released long enough to settle.
  task automatic applyStimulus(input logic [7:0] data);
    load_data   = data;
    load_strobe = 1'b1;
    tick(10);
    load_strobe = 1'b0;
    tick(10);
  endtask

  function automatic logic [7:0] expCk(input logic [7:0] s);
`ifdef PROGRAM_CHECKSUM_EN
    return s;
`else
    return 8'h00 & s;
`endif
  endfunction

  initial begin
    reset = 1'b1; mode_load = 1'b0; load_strobe = 1'b0;
    load_data = 8'h00; instruction_address = 8'h00;
    tick(3);
    checkOutput("rst_state", 16'(state), 16'h0);
    checkOutput("rst_cpu_reset", 16'(cpu_reset), 16'h1);
    checkOutput("rst_instruction", 16'(instruction), 16'h00);
    checkOutput("rst_load_address", 16'(load_address), 16'h00);
    checkOutput("rst_load_full", 16'(load_full), 16'h0);
    checkOutput("rst_checksum", 16'(checksum), 16'h00);

    // Test 1: single IDLE cycle, then RUN, cpu_reset drops a cycle later
    reset = 1'b0;
    tick(1);
    checkOutput("t1_state_run", 16'(state), 16'h2);
    checkOutput("t1_cpu_reset_still_1", 16'(cpu_reset), 16'h1);
    checkOutput("t1_instruction_zero", 16'(instruction), 16'h00);
    tick(1);
    checkOutput("t1_cpu_reset_0", 16'(cpu_reset), 16'h0);

    // Test 2: load three bytes and fetch them back
    mode_load = 1'b1;
    tick(1);
    checkOutput("t2_state_load", 16'(state), 16'h1);
    tick(1);
    checkOutput("t2_cpu_reset_1", 16'(cpu_reset), 16'h1);
    checkOutput("t2_addr_cleared", 16'(load_address), 16'h00);
    sum_model = 8'h00;
    applyStimulus(8'h1B); sum_model += 8'h1B;
    applyStimulus(8'h5E); sum_model += 8'h5E;
    applyStimulus(8'hC1); sum_model += 8'hC1;
    checkOutput("t2_load_address", 16'(load_address), 16'h03);
    checkOutput("t2_checksum", 16'(checksum), 16'(expCk(sum_model)));
    mode_load = 1'b0; instruction_address = 8'h01;
    tick(1);
    checkOutput("t2_state_run", 16'(state), 16'h2);
    checkOutput("t2_instr_lag", 16'(instruction), 16'h00);
    tick(1);
    checkOutput("t2_instr_addr1", 16'(instruction), 16'h5E);
    instruction_address = 8'h00; tick(1);
    checkOutput("t2_instr_addr0", 16'(instruction), 16'h1B);
    instruction_address = 8'h02; tick(1);
    checkOutput("t2_instr_addr2", 16'(instruction), 16'hC1);
    checkOutput("t2_checksum_hold", 16'(checksum), 16'(expCk(sum_model)));

    // Test 3: bouncing strobe never debounces
    mode_load = 1'b1; tick(2);
    applyStimulus(8'h77);
    checkOutput("t3_addr_before", 16'(load_address), 16'h01);
    for (int i = 0; i < 6; i++) begin
      load_strobe = ~load_strobe;
      tick(1);
    end
    load_strobe = 1'b0;
    tick(12);
    checkOutput("t3_addr_unchanged", 16'(load_address), 16'h01);

    // Test 4: fill every location, then an extra press is ignored
    mode_load = 1'b0; tick(2);
    mode_load = 1'b1; tick(2);
    checkOutput("t4_addr_cleared", 16'(load_address), 16'h00);
    sum_model = 8'h00;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(8'(i + 8'h30));
      sum_model += 8'(i + 8'h30);
      if (i == 254) begin
        checkOutput("t4_addr_255", 16'(load_address), 16'hFF);
        checkOutput("t4_not_full_yet", 16'(load_full), 16'h0);
      end
    end
    first_byte = 8'h30;
    checkOutput("t4_load_full", 16'(load_full), 16'h1);
    checkOutput("t4_addr_wrapped", 16'(load_address), 16'h00);
    applyStimulus(8'hAA);
    checkOutput("t4_full_addr_hold", 16'(load_address), 16'h00);
    checkOutput("t4_full_sticky", 16'(load_full), 16'h1);
    checkOutput("t4_checksum", 16'(checksum), 16'(expCk(sum_model)));
    mode_load = 1'b0; instruction_address = 8'h00;
    tick(2);
    checkOutput("t4_mem0_kept", 16'(instruction), 16'(first_byte));
    instruction_address = 8'hFF; tick(1);
    checkOutput("t4_mem255", 16'(instruction), 16'h2F);

    // Test 5: reset mid-load keeps RAM contents
    mode_load = 1'b1; tick(2);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    load_strobe = 1'b1; tick(3);
    reset = 1'b1; tick(1);
    load_strobe = 1'b0; mode_load = 1'b0; tick(2);
    checkOutput("t5_state_idle", 16'(state), 16'h0);
    checkOutput("t5_addr_reset", 16'(load_address), 16'h00);
    checkOutput("t5_cpu_reset", 16'(cpu_reset), 16'h1);
    checkOutput("t5_checksum_reset", 16'(checksum), 16'h00);
    reset = 1'b0; instruction_address = 8'h00;
    tick(3);
    checkOutput("t5_mem0", 16'(instruction), 16'h11);
    instruction_address = 8'h01; tick(1);
    checkOutput("t5_mem1", 16'(instruction), 16'h22);
    instruction_address = 8'h02; tick(1);
    checkOutput("t5_mem2_untouched", 16'(instruction), 16'h32);

    // Test 6: checksum wraps, holds in RUN, clears on re-entering LOAD
    mode_load = 1'b1; tick(2);
    checkOutput("t6_ck_start", 16'(checksum), 16'h00);
    applyStimulus(8'hF0);
    applyStimulus(8'h20);
    checkOutput("t6_ck_wrap", 16'(checksum), 16'(expCk(8'h10)));
    mode_load = 1'b0; tick(3);
    checkOutput("t6_ck_run_hold", 16'(checksum), 16'(expCk(8'h10)));
    mode_load = 1'b1; tick(2);
    checkOutput("t6_ck_cleared", 16'(checksum), 16'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
